// File: rtl/vlsu_pkg.sv
// Shared types and default sizes for the vector load/store unit.
// Latency/backpressure: n/a (types only).
package vlsu_pkg;

  localparam int LANES  = 8;
  localparam int N_DEF  = 20;
  localparam int AW_DEF = 10;

  typedef logic [2:0] lane_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    LOAD_WAIT,
    DONE
  } vlsu_state_t;

endpackage

// File: rtl/lsu_addr_gen.sv
// Lane address generator: base + k*stride, wrapping modulo 2^AW.
// Latency: combinational; backpressure: none.
module lsu_addr_gen
  import vlsu_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] base,
  input  lane_idx_t     k,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr
);

  assign addr = base + AW'(k) * stride;

endmodule

// File: rtl/vector_lsu.sv
// Serialises an 8-lane vector load/store onto one N-bit RAM port; optional VLSU_STRIDE_EN adds StrideM.
// Latency: store 9 / load 10 stall cycles then one DONE cycle; backpressure: Stall freezes the pipeline.
module vector_lsu
  import vlsu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MemWriteM,
  input  logic                 MemReadM,
  input  logic [N-1:0]         AddrM,
`ifdef VLSU_STRIDE_EN
  input  logic [AW-1:0]        StrideM,
`endif
  input  logic [7:0][N-1:0]    writeDataM,
  output logic [7:0][N-1:0]    RDM,
  output logic                 Stall,
  output logic [AW-1:0]        mem_addr,
  output logic [N-1:0]         mem_wdata,
  output logic                 mem_we,
  input  logic [N-1:0]         mem_rdata
);

  vlsu_state_t   state, state_nx;
  lane_idx_t     k;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [AW-1:0] lane_addr;
  logic          req;
  logic          last_lane;
  logic          unused_addr_hi;

  assign req            = MemWriteM | MemReadM;
  assign last_lane      = (k == lane_idx_t'(LANES - 1));
  assign unused_addr_hi = ^AddrM[N-1:AW];

`ifdef VLSU_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stride_q <= '0;
    end else if (state == IDLE && req) begin
      stride_q <= StrideM;
    end
  end

  assign stride = stride_q;
`else
  assign stride = AW'(1);
`endif

  lsu_addr_gen #(.AW(AW)) u_addr_gen (
    .base   (base),
    .k      (k),
    .stride (stride),
    .addr   (lane_addr)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      k     <= '0;
      base  <= '0;
      RDM   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            base <= AddrM[AW-1:0];
            k    <= '0;
          end
        end
        STORE: k <= k + 3'd1;
        LOAD: begin
          k <= k + 3'd1;
          // RAM data returned this cycle belongs to the previous lane's read
          if (k != '0) RDM[k - 3'd1] <= mem_rdata;
        end
        LOAD_WAIT: RDM[lane_idx_t'(LANES - 1)] <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    Stall     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        Stall = req;
        if (MemWriteM)     state_nx = STORE;
        else if (MemReadM) state_nx = LOAD;
      end
      STORE: begin
        Stall     = 1'b1;
        mem_we    = RST;
        mem_addr  = lane_addr;
        mem_wdata = writeDataM[k];
        if (last_lane) state_nx = DONE;
      end
      LOAD: begin
        Stall    = 1'b1;
        mem_addr = lane_addr;
        if (last_lane) state_nx = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        Stall    = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
